// File: rtl/diod_pkg.sv
// Constants and types shared by the diode bias controller and its serial DAC writer.
package diod_pkg;

    localparam int FRAME_W = 16;
    localparam int CODE_W  = 8;

    localparam logic [3:0] DEF_CTRL_BITS = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } dac_state_t;

    // DAC word layout: command nibble, code, four don't-care LSBs sent as zero.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] ctrl,
                                                      input logic [CODE_W-1:0] c);
        return {ctrl, c, 4'b0000};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock divider: CLK_DIV cycles per half-period, idle low while disabled.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic spi_clk,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;
    logic             phase_end;

    // rise/fall flag the cycle whose closing edge flips spi_clk
    assign phase_end = en && (cnt == DIV_LAST);
    assign rise      = phase_end && !spi_clk;
    assign fall      = phase_end && spi_clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            spi_clk <= 1'b0;
        end else if (phase_end) begin
            cnt     <= '0;
            spi_clk <= ~spi_clk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_dac_writer.sv
// Serial DAC write engine: frames an 8-bit bias code into a 16-bit word and
// shifts it out in SPI mode 0, with a one-deep pending slot for the next code.
module spi_dac_writer
    import diod_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter int         SS_SETUP  = 2,
    parameter int         SS_HOLD   = 2,
    parameter int         SS_GAP    = 4,
    parameter logic [3:0] CTRL_BITS = DEF_CTRL_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] last_code,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_ss
);

    localparam int CNT_MAX = (SS_SETUP > SS_HOLD) ?
                             ((SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP) :
                             ((SS_HOLD  > SS_GAP) ? SS_HOLD  : SS_GAP);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int BIT_W = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(SS_GAP - 1);
    localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(FRAME_W);

    dac_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [CODE_W-1:0]  cur_code;
    logic [CODE_W-1:0]  pend_code;
    logic               pend_vld;

    logic               sck_rise;
    logic               sck_fall;
    logic               load_now;
    logic [CODE_W-1:0]  load_code;
    logic [FRAME_W-1:0] load_frame;

    // MSB of the shift register drives the pin directly, so mosi is a flop output
    assign spi_mosi = shreg[FRAME_W-1];

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (state == SHIFT),
        .spi_clk (spi_clk),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    // A strobe coinciding with the end of GAP is the newest code, so it beats the slot.
    always_comb begin
        load_now  = 1'b0;
        load_code = code;
        case (state)
            IDLE: load_now = start;
            GAP: begin
                if (cnt == GAP_LAST) begin
                    if (start) begin
                        load_now = 1'b1;
                    end else if (pend_vld) begin
                        load_now  = 1'b1;
                        load_code = pend_code;
                    end
                end
            end
            default: ;
        endcase
    end

    assign load_frame = make_frame(CTRL_BITS, load_code);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            cur_code  <= '0;
            pend_code <= '0;
            pend_vld  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            last_code <= '0;
            spi_ss    <= 1'b1;
        end else begin
            done <= 1'b0;
            if (start && !load_now) begin
                pend_vld  <= 1'b1;
                pend_code <= code;
            end
            if (load_now) begin
                state    <= SETUP;
                cnt      <= '0;
                shreg    <= load_frame;
                cur_code <= load_code;
                pend_vld <= 1'b0;
                busy     <= 1'b1;
                spi_ss   <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            state   <= SHIFT;
                            cnt     <= '0;
                            bit_cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SHIFT: begin
                        // bits are counted on rise; data advances on fall
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (sck_fall) begin
                            if (bit_cnt == BITS_ALL) begin
                                state <= HOLD;
                                cnt   <= '0;
                            end else begin
                                shreg <= {shreg[FRAME_W-2:0], 1'b0};
                            end
                        end
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state     <= GAP;
                            cnt       <= '0;
                            spi_ss    <= 1'b1;
                            shreg     <= '0;
                            done      <= 1'b1;
                            last_code <= cur_code;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == GAP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_dac_writer.sv
// Directed bench for spi_dac_writer: default instance plus a minimum-timing instance.
module tb_spi_dac_writer;

    typedef struct {
        int          id;
        int          len;
        int          nbits;
        logic [15:0] bits;
        logic [7:0]  lc;
        logic        dn;
    } frame_t;

    typedef struct {
        logic [7:0] code;
        int         seq;
    } load_t;

    logic       clk = 1'b0;
    logic       rst0 = 1'b0, rst1 = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] code0 = '0, code1 = '0;
    logic       busy0, done0, sck0, mosi0, ss0;
    logic       busy1, done1, sck1, mosi1, ss1;
    logic [7:0] lc0, lc1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_dac_writer dut0 (
        .clk(clk), .reset(rst0), .start(start0), .code(code0),
        .busy(busy0), .done(done0), .last_code(lc0),
        .spi_clk(sck0), .spi_mosi(mosi0), .spi_ss(ss0)
    );

    spi_dac_writer #(
        .CLK_DIV(1), .SS_SETUP(1), .SS_HOLD(1), .SS_GAP(1)
    ) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .code(code1),
        .busy(busy1), .done(done1), .last_code(lc1),
        .spi_clk(sck1), .spi_mosi(mosi1), .spi_ss(ss1)
    );

    logic       rst_w[2], ss_w[2], sck_w[2], mosi_w[2], busy_w[2], done_w[2];
    logic [7:0] lc_w[2];
    assign rst_w[0] = rst0;   assign rst_w[1] = rst1;
    assign ss_w[0] = ss0;     assign ss_w[1] = ss1;
    assign sck_w[0] = sck0;   assign sck_w[1] = sck1;
    assign mosi_w[0] = mosi0; assign mosi_w[1] = mosi1;
    assign busy_w[0] = busy0; assign busy_w[1] = busy1;
    assign done_w[0] = done0; assign done_w[1] = done1;
    assign lc_w[0] = lc0;     assign lc_w[1] = lc1;

    // Stimulus-side record of the newest strobe actually sampled by dut0.
    logic [7:0] sb_code = '0;
    int         sb_seq = 0;

    frame_t fq[$];
    load_t  loadq[$];
    int     gq[$];

    int          len[2] = '{0, 0}, nb[2] = '{0, 0}, hi[2] = '{0, 0};
    int          nframes[2] = '{0, 0}, done_cnt[2] = '{0, 0};
    int          unstable[2] = '{0, 0}, bfall[2] = '{0, 0}, blag[2] = '{0, 0};
    logic [15:0] acc[2] = '{16'h0, 16'h0};
    logic        pss[2] = '{1'b1, 1'b1}, psck[2] = '{1'b0, 1'b0};
    logic        pmosi[2] = '{1'b0, 1'b0}, pbusy[2] = '{1'b0, 1'b0};
    bit          had_frame[2] = '{1'b0, 1'b0};

    // Bus monitor: reconstructs frames from the SPI pins, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_w[i]) begin
                len[i] = 0; nb[i] = 0; acc[i] = '0; had_frame[i] = 1'b0;
            end else begin
                if (done_w[i]) done_cnt[i]++;
                if (pbusy[i] && !busy_w[i]) begin
                    bfall[i]++;
                    blag[i] = hi[i];
                end
                if (!ss_w[i]) begin
                    if (pss[i]) begin
                        if (i == 0 && had_frame[i]) gq.push_back(hi[i]);
                        if (i == 0) begin
                            load_t l;
                            l.code = sb_code;
                            l.seq  = sb_seq;
                            loadq.push_back(l);
                        end
                        len[i] = 0; nb[i] = 0; acc[i] = '0;
                    end
                    len[i]++;
                    if (sck_w[i] && !psck[i]) begin
                        acc[i] = {acc[i][14:0], mosi_w[i]};
                        nb[i]++;
                        if (mosi_w[i] !== pmosi[i]) unstable[i]++;
                    end
                end else begin
                    if (!pss[i]) begin
                        frame_t f;
                        f.id = i; f.len = len[i]; f.nbits = nb[i]; f.bits = acc[i];
                        f.lc = lc_w[i]; f.dn = done_w[i];
                        fq.push_back(f);
                        nframes[i]++;
                        had_frame[i] = 1'b1;
                        hi[i] = 0;
                    end
                    hi[i]++;
                end
            end
            pss[i] = ss_w[i]; psck[i] = sck_w[i]; pmosi[i] = mosi_w[i]; pbusy[i] = busy_w[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse0(input logic [7:0] c);
        start0 = 1'b1;
        code0  = c;
        @(posedge clk);
        sb_code = c;
        sb_seq++;
        #1;
        start0 = 1'b0;
    endtask

    task automatic pulse1(input logic [7:0] c);
        start1 = 1'b1;
        code1  = c;
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    task automatic wait_frames(input int id, input int target, input int budget);
        int k = 0;
        while (nframes[id] < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("frame_timeout", 32'(nframes[id] >= target), 32'd1);
    endtask

    task automatic wait_idle0(input int budget);
        int k = 0;
        while (busy0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_timeout", 32'(busy0), 32'd0);
    endtask

    task automatic next_frame(output frame_t f);
        if (fq.size() > 0) begin
            f = fq.pop_front();
        end else begin
            f = '{-1, 0, 0, 16'h0, 8'h0, 1'b0};
        end
    endtask

    initial begin
        frame_t f;
        load_t  l;
        int     base_done, base_fr, base_bf, k, prev_seq;

        // reset state
        tick(3);
        check("rst_ss", 32'(ss0), 32'd1);
        check("rst_sck", 32'(sck0), 32'd0);
        check("rst_mosi", 32'(mosi0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_last_code", 32'(lc0), 32'd0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        tick(2);

        // single frame 0xA5
        fq.delete();
        pulse0(8'hA5);
        check("a5_ss_low", 32'(ss0), 32'd0);
        check("a5_busy", 32'(busy0), 32'd1);
        check("a5_mosi_msb", 32'(mosi0), 32'd0);
        wait_frames(0, 1, 400);
        tick(10);
        next_frame(f);
        check("a5_ss_len", 32'(f.len), 32'd132);
        check("a5_nbits", 32'(f.nbits), 32'd16);
        check("a5_bits", 32'(f.bits), 32'h3A50);
        check("a5_done_at_rise", 32'(f.dn), 32'd1);
        check("a5_last_code", 32'(f.lc), 32'hA5);
        check("a5_done_count", 32'(done_cnt[0]), 32'd1);
        check("a5_busy_lag", 32'(blag[0]), 32'd4);

        // back-to-back with overwrite of the pending slot
        fq.delete();
        base_done = done_cnt[0];
        base_fr   = nframes[0];
        base_bf   = bfall[0];
        pulse0(8'h10);
        tick(40);
        gq.delete();
        pulse0(8'h20);
        tick(5);
        pulse0(8'h30);
        wait_frames(0, base_fr + 2, 800);
        tick(10);
        next_frame(f);
        check("b2b_f1_bits", 32'(f.bits), 32'h3100);
        check("b2b_f1_lc", 32'(f.lc), 32'h10);
        next_frame(f);
        check("b2b_f2_bits", 32'(f.bits), 32'h3300);
        check("b2b_f2_lc", 32'(f.lc), 32'h30);
        check("b2b_f2_len", 32'(f.len), 32'd132);
        check("b2b_gap_count", 32'(gq.size()), 32'd1);
        check("b2b_gap_len", 32'((gq.size() > 0) ? gq[0] : -1), 32'd4);
        check("b2b_busy_falls", 32'(bfall[0] - base_bf), 32'd1);
        check("b2b_done_count", 32'(done_cnt[0] - base_done), 32'd2);

        // reset mid-SHIFT with a pending code
        pulse0(8'h55);
        tick(61);
        pulse0(8'h66);
        tick(2);
        @(posedge clk);
        #3;
        rst0 = 1'b0;
        #1;
        check("midrst_ss", 32'(ss0), 32'd1);
        check("midrst_sck", 32'(sck0), 32'd0);
        check("midrst_mosi", 32'(mosi0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_last_code", 32'(lc0), 32'd0);
        tick(2);
        rst0 = 1'b1;
        base_fr = nframes[0];
        tick(200);
        check("midrst_no_pending", 32'(nframes[0] - base_fr), 32'd0);
        check("midrst_ss_idle", 32'(ss0), 32'd1);
        fq.delete();
        pulse0(8'h01);
        wait_frames(0, base_fr + 1, 400);
        tick(2);
        next_frame(f);
        check("post_rst_bits", 32'(f.bits), 32'h3010);
        check("post_rst_len", 32'(f.len), 32'd132);
        check("post_rst_lc", 32'(f.lc), 32'h01);

        // minimum-timing instance
        fq.delete();
        pulse1(8'hFF);
        wait_frames(1, 1, 200);
        tick(2);
        next_frame(f);
        check("min_id", 32'(f.id), 32'd1);
        check("min_ss_len", 32'(f.len), 32'd34);
        check("min_nbits", 32'(f.nbits), 32'd16);
        check("min_bits", 32'(f.bits), 32'h3FF0);
        check("min_lc", 32'(f.lc), 32'hFF);
        check("min_mosi_stable", 32'(unstable[1]), 32'd0);

        // start on the first cycle busy is low
        wait_idle0(400);
        fq.delete();
        base_done = done_cnt[0];
        base_fr   = nframes[0];
        pulse0(8'h77);
        k = 0;
        while (busy0 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("edge_busy_fell", 32'(busy0), 32'd0);
        pulse0(8'h88);
        check("edge_ss_low", 32'(ss0), 32'd0);
        check("edge_busy", 32'(busy0), 32'd1);
        wait_frames(0, base_fr + 2, 400);
        tick(10);
        next_frame(f);
        check("edge_f1_bits", 32'(f.bits), 32'h3770);
        next_frame(f);
        check("edge_f2_bits", 32'(f.bits), 32'h3880);
        check("edge_done_count", 32'(done_cnt[0] - base_done), 32'd2);

        // random strobe stream against the strobe-order scoreboard
        wait_idle0(400);
        fq.delete();
        loadq.delete();
        base_done = done_cnt[0];
        for (int s = 0; s < 200; s++) begin
            k = int'($urandom_range(0, 160));
            if (k > 0) tick(k);
            pulse0(8'($urandom));
        end
        wait_idle0(2000);
        tick(5);
        check("rnd_frames_vs_loads", 32'(fq.size()), 32'(loadq.size()));
        check("rnd_done_vs_frames", 32'(done_cnt[0] - base_done), 32'(fq.size()));
        prev_seq = 0;
        while (fq.size() > 0 && loadq.size() > 0) begin
            next_frame(f);
            l = loadq.pop_front();
            check("rnd_code", 32'(f.lc), 32'(l.code));
            check("rnd_bits", 32'(f.bits), {16'h0, 4'h3, l.code, 4'h0});
            check("rnd_fresh", 32'(l.seq > prev_seq), 32'd1);
            prev_seq = l.seq;
        end
        check("rnd_last_not_lost", 32'(prev_seq), 32'(sb_seq));
        check("mosi_stable_default", 32'(unstable[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
